// File: rtl/kyber_pkg.sv
// Shared Kyber constants, the per-pair gamma table and the basemul controller state type.
package kyber_pkg;

  localparam int unsigned Q = 3329;
  localparam int unsigned N = 256;
  localparam int unsigned AddrW = 8;
  localparam int unsigned DataW = 16;

  // gamma(i) = 17^(2*brv7(i)+1) mod Q; entries come in (z, Q-z) pairs.
  localparam logic [15:0] GAMMA [128] = '{
    16'd17,   16'd3312, 16'd2761, 16'd568,  16'd583,  16'd2746, 16'd2649, 16'd680,
    16'd1637, 16'd1692, 16'd723,  16'd2606, 16'd2288, 16'd1041, 16'd1100, 16'd2229,
    16'd1409, 16'd1920, 16'd2662, 16'd667,  16'd3281, 16'd48,   16'd233,  16'd3096,
    16'd756,  16'd2573, 16'd2156, 16'd1173, 16'd3015, 16'd314,  16'd3050, 16'd279,
    16'd1703, 16'd1626, 16'd1651, 16'd1678, 16'd2789, 16'd540,  16'd1789, 16'd1540,
    16'd1847, 16'd1482, 16'd952,  16'd2377, 16'd1461, 16'd1868, 16'd2687, 16'd642,
    16'd939,  16'd2390, 16'd2308, 16'd1021, 16'd2437, 16'd892,  16'd2388, 16'd941,
    16'd733,  16'd2596, 16'd2337, 16'd992,  16'd268,  16'd3061, 16'd641,  16'd2688,
    16'd1584, 16'd1745, 16'd2298, 16'd1031, 16'd2037, 16'd1292, 16'd3220, 16'd109,
    16'd375,  16'd2954, 16'd2549, 16'd780,  16'd2090, 16'd1239, 16'd1645, 16'd1684,
    16'd1063, 16'd2266, 16'd319,  16'd3010, 16'd2773, 16'd556,  16'd757,  16'd2572,
    16'd2099, 16'd1230, 16'd561,  16'd2768, 16'd2466, 16'd863,  16'd2594, 16'd735,
    16'd2804, 16'd525,  16'd1092, 16'd2237, 16'd403,  16'd2926, 16'd1026, 16'd2303,
    16'd1143, 16'd2186, 16'd2150, 16'd1179, 16'd2775, 16'd554,  16'd886,  16'd2443,
    16'd1722, 16'd1607, 16'd1212, 16'd2117, 16'd1874, 16'd1455, 16'd1029, 16'd2300,
    16'd2110, 16'd1219, 16'd2935, 16'd394,  16'd885,  16'd2444, 16'd2154, 16'd1175
  };

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

endpackage

// File: rtl/poly_basemul_ctrl_if.sv
// Start/done handshake plus A/B read ports and C write port of the basemul controller.
interface poly_basemul_ctrl_if
  import kyber_pkg::*;
();
  logic             start;
  logic             busy;
  logic             done;
  logic [AddrW-1:0] a_raddr;
  logic [AddrW-1:0] b_raddr;
  logic [DataW-1:0] a_rdata;
  logic [DataW-1:0] b_rdata;
  logic             c_we;
  logic [AddrW-1:0] c_waddr;
  logic [DataW-1:0] c_wdata;

  modport master (
    input  start, a_rdata, b_rdata,
    output busy, done, a_raddr, b_raddr, c_we, c_waddr, c_wdata
  );

  modport slave (
    output start, a_rdata, b_rdata,
    input  busy, done, a_raddr, b_raddr, c_we, c_waddr, c_wdata
  );
endinterface

// File: rtl/base_case_multiply.sv
// Combinational Kyber pair product in Z_q[X]/(X^2 - gamma); operands need not be reduced.
module base_case_multiply
  import kyber_pkg::*;
(
  input  logic [15:0] a0,
  input  logic [15:0] a1,
  input  logic [15:0] b0,
  input  logic [15:0] b1,
  input  logic [15:0] gamma,
  output logic [15:0] c0,
  output logic [15:0] c1
);
  logic [47:0] t0;
  logic [47:0] t1;

  always_comb begin
    t0 = 48'(a0) * 48'(b0) + 48'(a1) * 48'(b1) * 48'(gamma);
    t1 = 48'(a0) * 48'(b1) + 48'(a1) * 48'(b0);
    c0 = 16'(t0 % 48'(Q));
    c1 = 16'(t1 % 48'(Q));
  end
endmodule

// File: rtl/poly_basemul_ctrl.sv
// Streams 128 coefficient pairs from A/B through base_case_multiply and writes 256 words to C.
module poly_basemul_ctrl
  import kyber_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  poly_basemul_ctrl_if.master bus
);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(N - 1);

  state_e             state_q;
  logic [AddrW-1:0]   rd_cnt_q;
  logic [1:0]         drain_cnt_q;
  logic               rd_vld_q;
  logic               rd_ph_q;
  logic [AddrW-2:0]   rd_pair_q;
  logic [DataW-1:0]   a0_q;
  logic [DataW-1:0]   b0_q;
  logic [DataW-1:0]   c1_q;
  logic               wr_c1_q;
  logic               busy_q;
  logic               done_q;
  logic               c_we_q;
  logic [AddrW-1:0]   c_waddr_q;
  logic [DataW-1:0]   c_wdata_q;
  logic [DataW-1:0]   mul_c0;
  logic [DataW-1:0]   mul_c1;

  // a1/b1 come straight off the RAM data port in the odd-data cycle; c0 is
  // registered at the end of that cycle, so rdata never reaches an output.
  base_case_multiply u_mul (
    .a0    (a0_q),
    .a1    (bus.a_rdata),
    .b0    (b0_q),
    .b1    (bus.b_rdata),
    .gamma (GAMMA[rd_pair_q]),
    .c0    (mul_c0),
    .c1    (mul_c1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      drain_cnt_q <= '0;
      rd_vld_q    <= 1'b0;
      rd_ph_q     <= 1'b0;
      rd_pair_q   <= '0;
      a0_q        <= '0;
      b0_q        <= '0;
      c1_q        <= '0;
      wr_c1_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      c_we_q      <= 1'b0;
      c_waddr_q   <= '0;
      c_wdata_q   <= '0;
    end else begin
      // Read data is valid one cycle after its address; track which half it is.
      rd_vld_q  <= (state_q == RUN);
      rd_ph_q   <= rd_cnt_q[0];
      rd_pair_q <= rd_cnt_q[AddrW-1:1];
      wr_c1_q   <= rd_vld_q & rd_ph_q;
      c_we_q    <= (rd_vld_q & rd_ph_q) | wr_c1_q;

      if (rd_vld_q && !rd_ph_q) begin
        a0_q <= bus.a_rdata;
        b0_q <= bus.b_rdata;
      end

      if (rd_vld_q && rd_ph_q) begin
        c_waddr_q <= {rd_pair_q, 1'b0};
        c_wdata_q <= mul_c0;
        c1_q      <= mul_c1;
      end else if (wr_c1_q) begin
        c_waddr_q <= {c_waddr_q[AddrW-1:1], 1'b1};
        c_wdata_q <= c1_q;
      end

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q  <= RUN;
            rd_cnt_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        RUN: begin
          if (rd_cnt_q == LastAddr) begin
            state_q     <= DRAIN;
            drain_cnt_q <= '0;
          end else begin
            rd_cnt_q <= rd_cnt_q + AddrW'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt_q == 2'd2) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + 2'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.a_raddr = rd_cnt_q;
  assign bus.b_raddr = rd_cnt_q;
  assign bus.c_we    = c_we_q;
  assign bus.c_waddr = c_waddr_q;
  assign bus.c_wdata = c_wdata_q;
endmodule

// File: doc/poly_basemul_ctrl.md
# poly_basemul_ctrl

Sequential initiator for the NTT-domain pointwise product of two Kyber polynomials. It streams 128 coefficient pairs from the A and B coefficient RAMs and drives the existing combinational pair multiplier with the per-pair gamma constant. It writes the 256 result coefficients to the C RAM, then reports completion with a start/done handshake. It sits between the forward NTT result buffers and the inverse-NTT input buffer.

## Interface
- Q, 3329: Kyber modulus.
- N, 256: coefficients per polynomial (128 pairs).
- clk  in  1  rising-edge clock; one clock domain.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- busy  out  1  high from first read cycle through last write cycle.
- done  out  1  one-cycle pulse after the last write.
- a_raddr, b_raddr  out  8 each  coefficient read addresses.
- a_rdata, b_rdata  in  16 each  read data, valid the cycle after the address (synchronous RAM).
- c_we  out  1  write strobe.
- c_waddr  out  8  write address.
- c_wdata  out  16  write data, always in [0, Q-1].

## Operation
- FSM: IDLE -> RUN on start. RUN -> DRAIN after 256 read cycles. DRAIN -> DONE after 3 cycles. DONE -> IDLE after 1 cycle.
- RUN: 8-bit read counter r = 0..255; a_raddr = b_raddr = r. Pair index i = r[7:1]; phase = r[0].
- Operand capture: data for address 2i is latched as a0/b0, and data for 2i+1 as a1/b1, each one cycle after its address.
- gamma(i) = 17^(2·brv7(i)+1) mod Q, read from a 128-entry constant table indexed by i.
  - gamma[0] = 17, [1] = 3312, [2] = 2761, [3] = 568.
  - Pairs are (z, Q−z).
- Multiply on registered operands:
  - c0 = (a0·b0 + a1·b1·gamma) mod Q.
  - c1 = (a0·b1 + a1·b0) mod Q.
  - Intermediates are at least 48 bits unsigned; full 16-bit operands are accepted with no pre-reduction.
- Writes: c0 to address 2i, then c1 (registered) to 2i+1 on the following cycle.
- start while busy or in DONE: ignored.
- rst in any state, including mid-RUN:
  - Next cycle: state IDLE, busy = 0, done = 0, c_we = 0, all addresses and c_wdata = 0.
  - No done pulse is produced for the aborted run; C contents are undefined.
- Reset values: every output is 0.

## Timing
- Let S be the cycle in which start is sampled high in IDLE.
- Pair i read addresses: 2i at cycle S+1+2i, 2i+1 at S+2+2i.
- Pair i writes: c0 at S+4+2i, c1 at S+5+2i. c_we is high continuously from S+4 to S+259.
- busy is high S+1..S+259. done is high at S+260 only, with busy low. The controller is back in IDLE at S+261, where a new start is accepted.
- Total latency from start to done is 260 cycles; throughput is 2 cycles per pair.
- Address outputs hold their last value outside RUN.
- c_waddr/c_wdata are don't-care when c_we = 0, but are driven from registers (no combinational path from rdata to outputs).

## Structure
- Package kyber_pkg holds:
  - Q, N.
  - The 128-entry GAMMA constant array (16-bit).
  - The FSM state enum {IDLE, RUN, DRAIN, DONE}.
- One sub-module: the existing combinational pair multiplier base_case_multiply, with a0/a1/b0/b1/gamma in and c0/c1 out. It is instantiated once and fed from the operand registers.
- Counter, operand and output registers plus the FSM live in poly_basemul_ctrl.

## Test plan
- A and B all zero except A[0] = B[0] = 1, start -> C[0] = 1, all other C = 0. done is seen exactly 260 cycles after start.
- A[1] = B[1] = 1, rest 0 -> C[0] = 17, C[1] = 0. A[3] = B[3] = 1 -> C[2] = 3312. A[5] = B[5] = 1 -> C[4] = 2761.
- A[0] = 1, B[1] = 1 -> C[1] = 1. Also A[0] = B[0] = 3328 -> C[0] = 1 (modular wrap). Also A[0] = B[0] = 0xFFFF -> C[0] = 65535² mod 3329.
- Random reduced A and B -> all 256 C words match a golden model, and the c_we address sequence is exactly 0..255 in order.
- start pulsed again at S+50 and held high during DONE -> ignored, one done only. back-to-back start at S+261 -> second run with identical timing.
- rst asserted at S+100 -> next cycle busy = 0, c_we = 0; no done pulse. A subsequent start produces a complete, correct result.
